// File: rtl/fifo_burst_reader.sv
// Drain stage for the RX merge FIFO. It requests a DDR write burst once enough words are queued,
// or a short residual burst after a flush, then streams the popped words out with valid/ready/last.
module fifo_burst_reader #(
    parameter int DATA_W      = 512,
    parameter int CNT_W       = 11,
    parameter int BURST_BEATS = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] fifo_dout_i,
    input  logic              fifo_empty_i,
    input  logic [CNT_W-1:0]  fifo_rd_data_count_i,
    output logic              fifo_rd_en_o,
    input  logic              flush_i,
    output logic              burst_req_o,
    output logic [7:0]        burst_len_o,
    input  logic              burst_ack_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o,
    output logic              busy_o,
    output logic [31:0]       burst_cnt_o
);

    localparam logic [1:0]       ST_IDLE  = 2'd0;
    localparam logic [1:0]       ST_REQ   = 2'd1;
    localparam logic [1:0]       ST_XFER  = 2'd2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BURST_BEATS);
    localparam logic [7:0]       FULL_LEN = 8'(BURST_BEATS);

    logic [1:0]        state;
    logic [7:0]        burst_len;
    logic [7:0]        pop_left;
    logic [7:0]        beat_left;
    logic              flush_pending;
    logic              partial_burst;
    logic              rd_inflight;
    logic [31:0]       burst_cnt;
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic [1:0]        buf_cnt;

    logic              in_xfer;
    logic              out_valid;
    logic              beat_fire;
    logic              last_fire;
    logic [2:0]        held;
    logic              rd_en;
    logic              start_full;
    logic              start_flush;
    logic              flush_clear;

    // Occupancy counts the beat leaving this cycle as gone, so a full-rate stream keeps one
    // word buffered and one read in flight without ever exceeding the two skid entries.
    always_comb begin
        in_xfer     = (state == ST_XFER);
        out_valid   = in_xfer && (buf_cnt != 2'd0);
        beat_fire   = out_valid && m_ready_i;
        last_fire   = beat_fire && (beat_left == 8'd1);
        held        = {1'b0, buf_cnt} + {2'b00, rd_inflight} - {2'b00, beat_fire};
        rd_en       = in_xfer && (pop_left != 8'd0) && !fifo_empty_i && (held < 3'd2);
        start_full  = (fifo_rd_data_count_i >= FULL_CNT);
        start_flush = flush_pending && (fifo_rd_data_count_i != '0);
        flush_clear = ((state == ST_IDLE) && flush_pending && !start_full &&
                       (fifo_rd_data_count_i == '0)) ||
                      (last_fire && partial_burst);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            burst_len     <= 8'd0;
            pop_left      <= 8'd0;
            beat_left     <= 8'd0;
            partial_burst <= 1'b0;
            burst_cnt     <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_full) begin
                        burst_len     <= FULL_LEN;
                        partial_burst <= 1'b0;
                        state         <= ST_REQ;
                    end else if (start_flush) begin
                        burst_len     <= 8'(fifo_rd_data_count_i);
                        partial_burst <= 1'b1;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (burst_ack_i) begin
                        pop_left  <= burst_len;
                        beat_left <= burst_len;
                        state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (rd_en) begin
                        pop_left <= pop_left - 8'd1;
                    end
                    if (beat_fire) begin
                        beat_left <= beat_left - 8'd1;
                    end
                    if (last_fire) begin
                        burst_cnt <= burst_cnt + 32'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A flush arriving mid-burst must survive the end of a residual burst.
            if (flush_i && (state != ST_IDLE)) begin
                partial_burst <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flush_pending <= 1'b0;
        end else begin
            flush_pending <= flush_i | (flush_pending & ~flush_clear);
        end
    end

    // Two-entry skid buffer; FIFO read data is captured the cycle after the pop strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_inflight <= 1'b0;
            buf0        <= '0;
            buf1        <= '0;
            buf_cnt     <= 2'd0;
        end else begin
            rd_inflight <= rd_en;
            if (beat_fire) begin
                if (buf_cnt == 2'd2) begin
                    buf0 <= buf1;
                    if (rd_inflight) begin
                        buf1 <= fifo_dout_i;
                    end else begin
                        buf_cnt <= 2'd1;
                    end
                end else if (rd_inflight) begin
                    buf0 <= fifo_dout_i;
                end else begin
                    buf_cnt <= 2'd0;
                end
            end else if (rd_inflight) begin
                if (buf_cnt == 2'd0) begin
                    buf0    <= fifo_dout_i;
                    buf_cnt <= 2'd1;
                end else begin
                    buf1    <= fifo_dout_i;
                    buf_cnt <= 2'd2;
                end
            end
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign burst_req_o  = (state == ST_REQ);
    assign burst_len_o  = burst_len;
    assign m_data_o     = buf0;
    assign m_valid_o    = out_valid;
    assign m_last_o     = out_valid && (beat_left == 8'd1);
    assign busy_o       = (state != ST_IDLE);
    assign burst_cnt_o  = burst_cnt;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT, and a scoreboard
// checks beat order, last placement, stall stability, pop rules and the burst counter every cycle.
module tb_fifo_burst_reader;

    localparam int DW = 512;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic [CW-1:0] fifo_cnt = '0;
    logic          fifo_rd_en;
    logic          flush = 1'b0;
    logic          burst_req;
    logic [7:0]    burst_len;
    logic          burst_ack = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic          busy;
    logic [31:0]   burst_cnt;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_W(DW), .CNT_W(CW), .BURST_BEATS(16)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .fifo_dout_i          (fifo_dout),
        .fifo_empty_i         (fifo_empty),
        .fifo_rd_data_count_i (fifo_cnt),
        .fifo_rd_en_o         (fifo_rd_en),
        .flush_i              (flush),
        .burst_req_o          (burst_req),
        .burst_len_o          (burst_len),
        .burst_ack_i          (burst_ack),
        .m_data_o             (m_data),
        .m_valid_o            (m_valid),
        .m_ready_i            (m_ready),
        .m_last_o             (m_last),
        .busy_o               (busy),
        .burst_cnt_o          (burst_cnt)
    );

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            seq = 1;
    int            pop_count = 0;
    int            delivered = 0;
    logic          hold_empty = 1'b0;
    int            ready_mode = 0;
    int            cur_len = 0;
    int            beat_idx = 0;
    int            model_bursts = 0;
    int            bursts_seen = 0;
    logic          xfer_window = 1'b0;
    int            valid_gaps = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] mk_word(input int s);
        logic [31:0] tag;
        tag = 32'(s);
        return {16{tag}};
    endfunction

    // FIFO model: pops on rd_en, read data appears the following cycle, count/empty registered.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_dout <= fifo_q.pop_front();
            pop_count++;
        end
        fifo_cnt   <= CW'(fifo_q.size());
        fifo_empty <= (fifo_q.size() == 0) || hold_empty;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) m_ready = 1'b1;
            else m_ready = ~m_ready;
        end
    end

    // Scoreboard: expected stream is the push order, bursts are cut at the announced length.
    always @(negedge clk) begin
        if (rstn) begin
            check_output("burst_cnt", DW'(burst_cnt), DW'(model_bursts));
            if (fifo_rd_en) check_output("pop_while_empty", DW'(fifo_empty), DW'(0));
            if (m_valid || fifo_rd_en)
                check_output("outstanding_le_2", DW'((pop_count - delivered) <= 2), DW'(1));
            if (prev_stall) begin
                check_output("stall_valid", DW'(m_valid), DW'(1));
                check_output("stall_data", m_data, prev_data);
                check_output("stall_last", DW'(m_last), DW'(prev_last));
            end
            if (xfer_window && !m_valid) valid_gaps++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_beat", DW'(1), DW'(0));
                end else begin
                    check_output("beat_data", m_data, exp_q.pop_front());
                end
                check_output("beat_last", DW'(m_last), DW'(beat_idx == cur_len - 1));
                delivered++;
                beat_idx++;
                if (beat_idx == cur_len) begin
                    beat_idx = 0;
                    model_bursts++;
                    bursts_seen++;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            beat_idx     = 0;
            model_bursts = 0;
            prev_stall   = 1'b0;
            delivered    = pop_count;
            exp_q        = fifo_q;
        end
    end

    task automatic apply_push(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(mk_word(seq));
            exp_q.push_back(mk_word(seq));
            seq++;
        end
    endtask

    task automatic apply_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_req(output logic seen);
        seen = burst_req;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = burst_req;
        end
        if (!seen) check_output("req_timeout", DW'(0), DW'(1));
    endtask

    task automatic apply_burst(input int exp_len, input int ack_dly, input bit chk_lat);
        logic          seen;
        logic [DW-1:0] first_word;
        int            start;
        wait_req(seen);
        if (seen) begin
            check_output("burst_len", DW'(burst_len), DW'(exp_len));
            check_output("busy_in_req", DW'(busy), DW'(1));
            repeat (ack_dly) @(negedge clk);
            check_output("req_held", DW'(burst_req), DW'(1));
            check_output("len_held", DW'(burst_len), DW'(exp_len));
            cur_len   = exp_len;
            start     = bursts_seen;
            burst_ack = 1'b1;
            @(negedge clk);
            burst_ack   = 1'b0;
            xfer_window = 1'b1;
            if (chk_lat) begin
                first_word = {16{32'h0000_0001}};
                check_output("lat_valid_c1", DW'(m_valid), DW'(0));
                @(negedge clk);
                check_output("lat_valid_c2", DW'(m_valid), DW'(0));
                @(negedge clk);
                check_output("lat_valid_c3", DW'(m_valid), DW'(1));
                check_output("first_word", m_data, first_word);
            end
            for (int i = 0; i < 2000 && bursts_seen == start; i++) @(negedge clk);
            if (bursts_seen == start) check_output("burst_timeout", DW'(0), DW'(1));
            xfer_window = 1'b0;
        end
    endtask

    task automatic check_no_req(input int cycles, input string name);
        logic any;
        any = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            any = any | burst_req;
        end
        check_output(name, DW'(any), DW'(0));
    endtask

    initial begin
        int   pops0;
        int   rem;
        logic seen;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        check_output("rst_valid", DW'(m_valid), DW'(0));
        check_output("rst_req", DW'(burst_req), DW'(0));
        check_output("rst_busy", DW'(busy), DW'(0));
        check_output("rst_cnt", DW'(burst_cnt), DW'(0));
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // ack outside REQ is ignored; a flush with an empty FIFO simply clears itself
        burst_ack = 1'b1;
        @(negedge clk);
        burst_ack = 1'b0;
        @(negedge clk);
        check_output("stray_ack_busy", DW'(busy), DW'(0));
        apply_flush();
        repeat (3) @(negedge clk);
        apply_push(3);
        check_no_req(20, "no_req_after_cleared_flush");
        apply_push(12);
        check_no_req(10, "no_req_at_15");

        // one more word reaches the full-burst threshold
        pops0 = pop_count;
        apply_push(1);
        apply_burst(16, 3, 1'b1);
        check_output("pops_full_burst", DW'(pop_count - pops0), DW'(16));
        check_output("cnt_after_first", DW'(burst_cnt), DW'(1));

        // residual burst after a flush, then silence
        apply_push(5);
        check_no_req(5, "no_req_at_5");
        apply_flush();
        apply_burst(5, 1, 1'b0);
        check_no_req(30, "no_req_after_residual");

        // toggling ready
        ready_mode = 1;
        apply_push(16);
        apply_burst(16, 0, 1'b0);
        ready_mode = 0;

        // FIFO reports empty for 10 cycles mid-burst
        apply_push(16);
        valid_gaps = 0;
        fork
            apply_burst(16, 2, 1'b0);
            begin
                for (int i = 0; i < 300 && !xfer_window; i++) @(negedge clk);
                repeat (4) @(negedge clk);
                hold_empty = 1'b1;
                repeat (10) @(negedge clk);
                hold_empty = 1'b0;
            end
        join
        check_output("valid_gaps_seen", DW'(valid_gaps >= 5), DW'(1));
        check_output("cnt_after_stall", DW'(burst_cnt), DW'(4));

        // flush during a burst with 20 more words queued: 16, then 16, then 4
        apply_push(36);
        fork
            apply_burst(16, 2, 1'b0);
            begin
                for (int i = 0; i < 300 && !xfer_window; i++) @(negedge clk);
                repeat (3) @(negedge clk);
                apply_flush();
            end
        join
        apply_burst(16, 1, 1'b0);
        apply_burst(4, 1, 1'b0);
        check_output("cnt_after_flush_seq", DW'(burst_cnt), DW'(7));
        check_no_req(30, "no_req_after_flush_seq");

        // reset during beat 7 of 16
        apply_push(16);
        wait_req(seen);
        if (seen) begin
            cur_len   = 16;
            burst_ack = 1'b1;
            @(negedge clk);
            burst_ack = 1'b0;
            for (int i = 0; i < 300 && beat_idx != 6; i++) @(negedge clk);
            check_output("reached_beat7", DW'(beat_idx), DW'(6));
            @(negedge clk);
            #2 rstn = 1'b0;
            #1;
            check_output("abort_valid", DW'(m_valid), DW'(0));
            check_output("abort_last", DW'(m_last), DW'(0));
            check_output("abort_rd_en", DW'(fifo_rd_en), DW'(0));
            check_output("abort_busy", DW'(busy), DW'(0));
            check_output("abort_req", DW'(burst_req), DW'(0));
            check_output("abort_cnt", DW'(burst_cnt), DW'(0));
            check_output("abort_data", m_data, DW'(0));
            repeat (2) @(negedge clk);
            rstn = 1'b1;
            rem = fifo_q.size();
            check_output("words_left_after_abort", DW'(rem >= 7 && rem <= 9), DW'(1));
            check_no_req(5, "no_req_after_abort");
            apply_flush();
            apply_burst(rem, 1, 1'b0);
            check_output("cnt_after_abort", DW'(burst_cnt), DW'(1));
        end

        repeat (5) @(negedge clk);
        check_output("scoreboard_drained", DW'(exp_q.size()), DW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got timeout, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
